// File: rtl/lb_ctrl.sv
// rtl/lb_ctrl.sv - round-robin line-buffer write steering and 3x3 window read controller
// Optional LB_CTRL_STATUS_EN adds o_fill_level and o_rows_out status outputs.
module lb_ctrl #(
   parameter int LINE_WIDTH = 512,
   parameter int FILL_W     = 12
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_pixel_data,
   input  logic              i_pixel_data_valid,
   output logic              o_ready,
   output logic [7:0]        o_lb_data,
   output logic [3:0]        o_lb_wr_valid,
   input  logic [23:0]       i_lb0_data,
   input  logic [23:0]       i_lb1_data,
   input  logic [23:0]       i_lb2_data,
   input  logic [23:0]       i_lb3_data,
   output logic [3:0]        o_lb_rd,
   output logic [71:0]       o_pixel_data,
   output logic              o_pixel_data_valid,
   output logic              o_intr,
   output logic              o_overflow
`ifdef LB_CTRL_STATUS_EN
   ,
   output logic [FILL_W-1:0] o_fill_level,
   output logic [15:0]       o_rows_out
`endif
);
   localparam int                COL_W      = $clog2(LINE_WIDTH);
   localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(4 * LINE_WIDTH);
   localparam logic [FILL_W-1:0] FILL_ROWS3 = FILL_W'(3 * LINE_WIDTH);
   localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(LINE_WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

   state_t              r_state;
   logic [COL_W-1:0]    r_wr_col;
   logic [COL_W-1:0]    r_rd_col;
   logic [1:0]          r_wr_buf;
   logic [1:0]          r_rd_buf;
   logic [FILL_W-1:0]   r_fill;
   logic                r_intr;
   logic                r_overflow;

   logic                w_wr_acc;
   logic                w_rd;
   logic [1:0]          w_rd_buf1;
   logic [1:0]          w_rd_buf2;
   logic [1:0]          w_rd_skip;
   logic [23:0]         w_lb [4];

   assign w_lb[0] = i_lb0_data;
   assign w_lb[1] = i_lb1_data;
   assign w_lb[2] = i_lb2_data;
   assign w_lb[3] = i_lb3_data;

   assign o_ready       = (r_fill < FILL_FULL);
   assign o_lb_data     = i_pixel_data;
   assign w_wr_acc      = i_pixel_data_valid & o_ready;
   assign o_lb_wr_valid = w_wr_acc ? (4'b0001 << r_wr_buf) : 4'b0000;

   // The one buffer not being read is rd_buf+3, so the read mask is its complement.
   assign w_rd               = (r_state == READ);
   assign w_rd_buf1          = r_rd_buf + 2'd1;
   assign w_rd_buf2          = r_rd_buf + 2'd2;
   assign w_rd_skip          = r_rd_buf + 2'd3;
   assign o_lb_rd            = w_rd ? ~(4'b0001 << w_rd_skip) : 4'b0000;
   assign o_pixel_data       = {w_lb[r_rd_buf], w_lb[w_rd_buf1], w_lb[w_rd_buf2]};
   assign o_pixel_data_valid = w_rd;
   assign o_intr             = r_intr;
   assign o_overflow         = r_overflow;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_col   <= '0;
         r_wr_buf   <= 2'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_col <= r_wr_col + 1'b1;
            if (r_wr_col == COL_LAST) begin
               r_wr_buf <= r_wr_buf + 2'd1;
            end
         end
         if (i_pixel_data_valid && !o_ready) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fill <= '0;
      end else begin
         case ({w_wr_acc, w_rd})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   // Start is judged on the registered fill, so a row begins one cycle after the threshold.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_rd_col <= '0;
         r_rd_buf <= 2'd0;
         r_intr   <= 1'b0;
      end else begin
         r_intr <= 1'b0;
         case (r_state)
            IDLE: begin
               r_rd_col <= '0;
               if (r_fill >= FILL_ROWS3) begin
                  r_state <= READ;
               end
            end
            READ: begin
               r_rd_col <= r_rd_col + 1'b1;
               if (r_rd_col == COL_LAST) begin
                  r_state  <= IDLE;
                  r_rd_buf <= r_rd_buf + 2'd1;
                  r_intr   <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef LB_CTRL_STATUS_EN
   logic [15:0] r_rows_out;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rows_out <= 16'd0;
      end else if (w_rd && (r_rd_col == COL_LAST)) begin
         r_rows_out <= r_rows_out + 16'd1;
      end
   end

   assign o_fill_level = r_fill;
   assign o_rows_out   = r_rows_out;
`endif

endmodule
